// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: packs the UART byte stream into RGB pixels, fills the frame
// RAM, then streams the frame out over valid/ready with a 2-entry skid FIFO.
//
// state   | meaning
// S_FILL  | packing bytes into pixels and writing them to the RAM
// S_DRAIN | reading the frame back and streaming it downstream
module rx_frame_ctrl #(
  parameter int RGB_WIDTH    = 24,
  parameter int IMG_WIDTH    = 80,
  parameter int IMG_HEIGHT   = 120,
  parameter int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
  parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  ram_we,
  output logic [RGB_WIDTH-1:0]  ram_wData,
  output logic [ADDR_WIDTH-1:0] ram_wAddr,
  output logic                  ram_frame_done,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_rAddr,
  input  logic [RGB_WIDTH-1:0]  ram_rData,
  output logic                  pix_valid,
  output logic [RGB_WIDTH-1:0]  pix_data,
  output logic                  pix_last,
  input  logic                  pix_ready,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_PIXELS - 1);

  state_t                state, state_nxt;
  logic [1:0]            byte_phase;
  logic [7:0]            r_byte, g_byte;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt;
  logic                  rd_all;
  logic                  rd_inflight, rd_inflight_last;
  logic [RGB_WIDTH-1:0]  fifo_data [2];
  logic                  fifo_last [2];
  logic                  fifo_head;
  logic [1:0]            fifo_cnt;
  logic [1:0]            occ;
  logic                  last_write, fill_byte, pix_pop, rd_issue, fifo_push;

  assign last_write = ram_we && (ram_wAddr == LAST_ADDR);
  // The final write cycle is the hand-over into S_DRAIN, so a byte landing there
  // is treated like a drain-time byte.
  assign fill_byte  = rx_valid && (state == S_FILL) && !last_write;
  assign pix_valid  = (fifo_cnt != 2'd0);
  assign pix_data   = fifo_data[fifo_head];
  assign pix_last   = pix_valid && fifo_last[fifo_head];
  assign pix_pop    = pix_valid && pix_ready;
  assign fifo_push  = rd_inflight;
  assign busy       = (state == S_DRAIN);
  assign occ        = fifo_cnt + {1'b0, rd_inflight} - {1'b0, pix_pop};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FILL;
    else       state <= state_nxt;
  end

  // Next-state and read-issue decode; a read goes out only while buffered plus
  // in-flight pixels stay below the FIFO depth.
  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    case (state)
      S_FILL: begin
        if (last_write) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        rd_issue = !reset && !rd_all && (occ < 2'd2);
        if (pix_pop && pix_last) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
    ram_oe    = rd_issue;
    ram_rAddr = rd_cnt;
  end

  // Byte packing, RAM write port, frame-done pulse and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_phase     <= 2'd0;
      r_byte         <= 8'd0;
      g_byte         <= 8'd0;
      wr_cnt         <= '0;
      ram_we         <= 1'b0;
      ram_wData      <= '0;
      ram_wAddr      <= '0;
      ram_frame_done <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      ram_we         <= 1'b0;
      ram_frame_done <= last_write;
      if (rx_valid && !fill_byte) overrun <= 1'b1;
      if (last_write) begin
        byte_phase <= 2'd0;
      end else if (fill_byte) begin
        case (byte_phase)
          2'd0: begin
            r_byte     <= rx_data;
            byte_phase <= 2'd1;
          end
          2'd1: begin
            g_byte     <= rx_data;
            byte_phase <= 2'd2;
          end
          default: begin
            ram_we     <= 1'b1;
            ram_wData  <= {r_byte, g_byte, rx_data};
            ram_wAddr  <= wr_cnt;
            wr_cnt     <= (wr_cnt == LAST_ADDR) ? '0 : wr_cnt + ADDR_WIDTH'(1);
            byte_phase <= 2'd0;
          end
        endcase
      end
    end
  end

  // Read counter, in-flight tracking and the 2-entry output FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt           <= '0;
      rd_all           <= 1'b0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
      fifo_head        <= 1'b0;
      fifo_cnt         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      rd_inflight      <= rd_issue;
      rd_inflight_last <= rd_issue && (rd_cnt == LAST_ADDR);
      if (rd_issue) begin
        if (rd_cnt == LAST_ADDR) rd_all <= 1'b1;
        else                     rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
      end
      if (state == S_DRAIN && state_nxt == S_FILL) begin
        rd_cnt <= '0;
        rd_all <= 1'b0;
      end
      if (fifo_push) begin
        fifo_data[fifo_head ^ fifo_cnt[0]] <= ram_rData;
        fifo_last[fifo_head ^ fifo_cnt[0]] <= rd_inflight_last;
      end
      if (pix_pop) fifo_head <= ~fifo_head;
      fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, pix_pop};
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl on a 4x2 frame with a behavioural frame RAM.
module tb_rx_frame_ctrl;
  localparam int AW   = 3;
  localparam int NPIX = 8;

  logic          clk = 1'b0;
  logic          reset, rx_valid, pix_ready;
  logic [7:0]    rx_data;
  logic          ram_we, ram_frame_done, ram_oe, pix_valid, pix_last, busy, overrun;
  logic [23:0]   ram_wData, ram_rData, pix_data;
  logic [AW-1:0] ram_wAddr, ram_rAddr;
  logic [23:0]   mem [NPIX];

  int passed = 0;
  int total  = 0;

  rx_frame_ctrl #(.RGB_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_we(ram_we), .ram_wData(ram_wData), .ram_wAddr(ram_wAddr),
    .ram_frame_done(ram_frame_done), .ram_oe(ram_oe), .ram_rAddr(ram_rAddr),
    .ram_rData(ram_rData), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .pix_ready(pix_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Frame RAM: 1-cycle write, registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_wAddr] <= ram_wData;
    if (ram_oe) ram_rData <= mem[ram_rAddr];
  end

  logic [AW-1:0] wa [$];
  logic [23:0]   wd [$];
  logic [23:0]   pd [$];
  logic          pl [$];
  int            pc [$];
  int cyc = 0, done_cnt = 0, done_bad = 0, done_cyc = 0, we_in_drain = 0;
  int stall_seen = 0, stall_bad = 0, issued = 0, accepted = 0, max_out = 0;
  logic        prev_we_last = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [23:0] prev_data = '0;

  // Observe the DUT on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (ram_we) begin
      wa.push_back(ram_wAddr);
      wd.push_back(ram_wData);
      if (busy) we_in_drain++;
    end
    if (ram_frame_done) begin
      done_cnt++;
      if (!prev_we_last || !busy) done_bad++;
      done_cyc = cyc;
    end
    prev_we_last = ram_we && (ram_wAddr == AW'(NPIX - 1));
    if (prev_stall) begin
      stall_seen++;
      if (!(pix_valid && pix_data === prev_data && pix_last === prev_last)) stall_bad++;
    end
    prev_stall = pix_valid && !pix_ready && !reset;
    prev_data  = pix_data;
    prev_last  = pix_last;
    if (reset) begin
      issued     = 0;
      accepted   = 0;
      prev_stall = 1'b0;
    end else begin
      if (ram_oe) issued++;
      if (pix_valid && pix_ready) begin
        accepted++;
        pd.push_back(pix_data);
        pl.push_back(pix_last);
        pc.push_back(cyc);
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
    end
  end

  function automatic logic [23:0] exp_pix(input logic [7:0] base, input int k);
    logic [7:0] b0;
    b0 = base + 8'(3 * k);
    return {b0, b0 + 8'd1, b0 + 8'd2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_frame(input logic [7:0] base, input int gap);
    for (int i = 0; i < 24; i++) send_byte(base + 8'(i), gap);
  endtask

  task automatic wait_pix(input int n, input int budget);
    int b;
    b = budget;
    while (pd.size() < n && b > 0) begin
      tick(1);
      b--;
    end
  endtask

  task automatic clear_logs();
    wa.delete();
    wd.delete();
    pd.delete();
    pl.delete();
    pc.delete();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctrl"}, 32'({ram_we, ram_frame_done, ram_oe, pix_valid, pix_last, busy, overrun}), 32'd0);
    chk({tag, "_wdata"}, 32'(ram_wData), 32'd0);
    chk({tag, "_waddr"}, 32'(ram_wAddr), 32'd0);
  endtask

  task automatic check_writes(input string tag, input logic [7:0] base);
    chk($sformatf("%s_wr_count", tag), 32'(wa.size()), NPIX);
    for (int k = 0; k < NPIX; k++) begin
      if (k < wa.size()) begin
        chk($sformatf("%s_wr_addr%0d", tag, k), 32'(wa[k]), 32'(k));
        chk($sformatf("%s_wr_data%0d", tag, k), 32'(wd[k]), 32'(exp_pix(base, k)));
      end
    end
  endtask

  task automatic check_pixels(input string tag, input logic [7:0] base);
    chk($sformatf("%s_pix_count", tag), 32'(pd.size()), NPIX);
    for (int k = 0; k < NPIX; k++) begin
      if (k < pd.size()) begin
        chk($sformatf("%s_pix_data%0d", tag, k), 32'(pd[k]), 32'(exp_pix(base, k)));
        chk($sformatf("%s_pix_last%0d", tag, k), 32'(pl[k]), 32'(k == NPIX - 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat [4];
    pat = '{1, 0, 0, 1};
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'd0;
    pix_ready = 1'b0;
    tick(3);
    check_idle("reset");
    reset = 1'b0;
    tick(1);

    // Spaced fill, downstream stalled so the frame parks in S_DRAIN.
    clear_logs();
    send_frame(8'h00, 2);
    tick(4);
    check_writes("fill_spaced", 8'h00);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_after_last_write", 32'(done_bad), 32'd0);
    chk("busy_after_fill", 32'(busy), 32'd1);
    chk("pix_valid_prefetched", 32'(pix_valid), 32'd1);
    chk("no_last_on_first", 32'(pix_last), 32'd0);

    // Drain with ready 1,0,0,1 then random stalls.
    for (int c = 0; c < 300 && pd.size() < NPIX; c++) begin
      pix_ready = (c < 4) ? pat[c][0] : 1'($urandom_range(0, 1));
      tick(1);
    end
    pix_ready = 1'b0;
    check_pixels("drain_stall", 8'h00);
    chk("stall_seen", 32'(stall_seen > 0), 32'd1);
    chk("stall_stable", 32'(stall_bad), 32'd0);
    chk("max_outstanding", 32'(max_out), 32'd2);
    tick(2);
    chk("busy_after_drain", 32'(busy), 32'd0);
    chk("oe_after_drain", 32'(ram_oe), 32'd0);

    // Back-to-back bytes, drain at full rate.
    clear_logs();
    pix_ready = 1'b1;
    send_frame(8'h40, 0);
    wait_pix(NPIX, 100);
    check_writes("fill_b2b", 8'h40);
    check_pixels("drain_full", 8'h40);
    if (pc.size() == NPIX) begin
      chk("first_pix_latency", 32'(pc[0] - done_cyc), 32'd2);
      chk("pix_consecutive", 32'(pc[NPIX-1] - pc[0]), 32'(NPIX - 1));
    end
    tick(2);
    chk("busy_after_full", 32'(busy), 32'd0);

    // Bytes arriving while draining are dropped and flag overrun.
    clear_logs();
    pix_ready = 1'b0;
    send_frame(8'h80, 1);
    tick(3);
    chk("overrun_before", 32'(overrun), 32'd0);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 1);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("no_we_in_drain", 32'(we_in_drain), 32'd0);
    chk("writes_unchanged", 32'(wa.size()), NPIX);
    pix_ready = 1'b1;
    wait_pix(NPIX, 100);
    check_pixels("drain_ovr", 8'h80);
    tick(2);
    clear_logs();
    send_frame(8'hA0, 0);
    wait_pix(NPIX, 100);
    check_writes("fill_after_ovr", 8'hA0);
    check_pixels("drain_after_ovr", 8'hA0);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    tick(2);

    // Reset after a partial frame.
    pix_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'hB0 + 8'(i), 0);
    reset = 1'b1;
    tick(2);
    check_idle("reset_partial");
    reset = 1'b0;
    tick(1);
    clear_logs();
    send_frame(8'hC0, 1);
    tick(3);
    check_writes("fill_after_rst", 8'hC0);
    chk("busy_before_rst", 32'(busy), 32'd1);

    // Reset mid-drain after a few pixels have gone out.
    pix_ready = 1'b1;
    tick(3);
    pix_ready = 1'b0;
    reset = 1'b1;
    tick(1);
    chk("rst_drain_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_drain_oe", 32'(ram_oe), 32'd0);
    chk("rst_drain_busy", 32'(busy), 32'd0);
    tick(1);
    check_idle("reset_drain");
    reset = 1'b0;
    tick(1);
    clear_logs();
    pix_ready = 1'b1;
    send_frame(8'hE0, 0);
    wait_pix(NPIX, 100);
    check_writes("fill_final", 8'hE0);
    check_pixels("drain_final", 8'hE0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
